// File: rtl/engine_array_pkg.sv
// Shared op codes, FSM state type and command legality check for engine_array.
package engine_array_pkg;

  localparam logic [2:0] OP_MAC = 3'd1;
  localparam logic [2:0] OP_MAX = 3'd4;
  localparam logic [2:0] OP_AVG = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_MAC) || (op == OP_MAX) || (op == OP_AVG);
  endfunction

endpackage

// File: rtl/engine_array_lane.sv
// One accumulator lane: MAC/MAX/AVG update with round-0 overwrite, plus output shift and width reduction.
// ENGINE_ARRAY_SAT_EN selects saturating output; otherwise the output is truncated.
module engine_array_lane
  import engine_array_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [2:0]        op,
  input  logic [4:0]        shift,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] mul;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    ext;
  logic signed [ACC_W-1:0]    val;

  always_comb begin
    mul   = $signed(data) * $signed(weight);
    prod  = ACC_W'(mul);
    ext   = ACC_W'($signed(data));
    acc_d = acc_q;
    if (en) begin
      case (op)
        OP_MAC:  acc_d = first ? prod : acc_q + prod;
        OP_MAX:  acc_d = (first || (ext > acc_q)) ? ext : acc_q;
        default: acc_d = first ? ext : acc_q + ext;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

`ifdef ENGINE_ARRAY_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    val = (op == OP_AVG) ? (acc_q >>> shift) : acc_q;
    if (val > SAT_MAX)      result = DATA_W'(SAT_MAX);
    else if (val < SAT_MIN) result = DATA_W'(SAT_MIN);
    else                    result = DATA_W'(val);
  end
`else
  always_comb begin
    val    = (op == OP_AVG) ? (acc_q >>> shift) : acc_q;
    result = DATA_W'(val);
  end
`endif

endmodule

// File: rtl/engine_array.sv
// Command FSM that deals FWFT operand beats round-robin across LANES accumulators,
// then drains one result per lane into the result FIFO.
module engine_array
  import engine_array_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_type,
  input  logic [31:0]       op_num,
  input  logic [4:0]        avg_shift,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DATA_W-1:0] out_result,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      num_q, num_d;
  logic [4:0]       shift_q, shift_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [31:0]      round_q, round_d;
  logic [CNT_W-1:0] wb_q, wb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [DATA_W-1:0] lane_res [LANES];

  assign in_rd_en   = (state_q == ST_LOAD) && !in_empty;
  assign out_wr_en  = (state_q == ST_WRITE) && !out_full;
  assign out_result = (state_q == ST_WRITE) ? lane_res[wb_q] : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    num_d   = num_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    round_d = round_q;
    wb_d    = wb_q;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_type;
          num_d   = op_num;
          shift_d = avg_shift;
          beat_d  = '0;
          round_d = '0;
          wb_d    = '0;
          if (!op_legal(op_type) || (op_num == '0)) error_d = 1'b1;
          else                                      state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_rd_en) begin
          if (beat_q == LAST) begin
            beat_d  = '0;
            round_d = round_q + 32'd1;
            // The final accumulator update lands on the same edge as the move to WRITE.
            if (round_q == num_q - 32'd1) state_d = ST_WRITE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (out_wr_en) begin
          if (wb_q == LAST) state_d = ST_DONE;
          else              wb_d    = wb_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      num_q   <= '0;
      shift_q <= '0;
      beat_q  <= '0;
      round_q <= '0;
      wb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      num_q   <= num_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      wb_q    <= wb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    engine_array_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (in_rd_en && (beat_q == CNT_W'(i))),
      .first  (round_q == '0),
      .op     (op_q),
      .shift  (shift_q),
      .data   (in_data),
      .weight (in_weight),
      .result (lane_res[i])
    );
  end

endmodule

// File: tb/tb_engine_array.sv
// Scoreboard bench for engine_array: 4-lane and 16-lane instances driven from FWFT FIFO models,
// expected lane results queued at command issue and popped on every result push.
module tb_engine_array;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start4, start16, sel;
  logic [2:0]    op_type;
  logic [31:0]   op_num;
  logic [4:0]    avg_shift;
  logic [DW-1:0] in_data, in_weight;
  logic          in_empty, out_full;

  logic          rd4, wr4, busy4, done4, err4;
  logic [DW-1:0] res4;
  logic          rd16, wr16, busy16, done16, err16;
  logic [DW-1:0] res16;

  logic          rd_en, wr_en, busy, done, error;
  logic [DW-1:0] result;

  assign rd_en  = sel ? rd16   : rd4;
  assign wr_en  = sel ? wr16   : wr4;
  assign busy   = sel ? busy16 : busy4;
  assign done   = sel ? done16 : done4;
  assign error  = sel ? err16  : err4;
  assign result = sel ? res16  : res4;

  engine_array #(.LANES(4), .DATA_W(DW), .ACC_W(40)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_type(op_type), .op_num(op_num),
    .avg_shift(avg_shift), .in_data(in_data), .in_weight(in_weight), .in_empty(in_empty),
    .in_rd_en(rd4), .out_result(res4), .out_wr_en(wr4), .out_full(out_full),
    .busy(busy4), .done(done4), .error(err4)
  );

  engine_array #(.LANES(16), .DATA_W(DW), .ACC_W(40)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .op_type(op_type), .op_num(op_num),
    .avg_shift(avg_shift), .in_data(in_data), .in_weight(in_weight), .in_empty(in_empty),
    .in_rd_en(rd16), .out_result(res16), .out_wr_en(wr16), .out_full(out_full),
    .busy(busy16), .done(done16), .error(err16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] d_q[$];
  logic signed [DW-1:0] w_q[$];
  logic signed [DW-1:0] exp_q[$];
  int ptr;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic logic signed [DW-1:0] model(input int lanes, input int l, input int op,
                                                  input int num, input int sh);
    longint acc;
    longint x;
    longint w;
    acc = 0;
    for (int r = 0; r < num; r++) begin
      x = longint'(d_q[r*lanes+l]);
      w = longint'(w_q[r*lanes+l]);
      case (op)
        1:       acc = (r == 0) ? x * w : acc + x * w;
        4:       acc = ((r == 0) || (x > acc)) ? x : acc;
        default: acc = (r == 0) ? x : acc + x;
      endcase
    end
    if (op == 5) acc = acc >>> sh;
`ifdef ENGINE_ARRAY_SAT_EN
    if (acc > 32767)       acc = 32767;
    else if (acc < -32768) acc = -32768;
`endif
    return acc[DW-1:0];
  endfunction

  task automatic fill_w(input logic signed [DW-1:0] v);
    w_q.delete();
    for (int i = 0; i < d_q.size(); i++) w_q.push_back(v);
  endtask

  task automatic drive_fifo(input bit stall);
    in_empty  = (ptr >= d_q.size()) || (stall && ($urandom_range(0, 2) == 0));
    in_data   = (ptr < d_q.size()) ? d_q[ptr] : '0;
    in_weight = (ptr < w_q.size()) ? w_q[ptr] : '0;
    out_full  = stall && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_cmd(input int lanes, input logic [2:0] op, input int num, input int sh,
                         input bit stall, input int exp_lat);
    int pops, pushes, cyc, lat;
    bit pop_f, fin;
    pops = 0; pushes = 0; cyc = 0; lat = -1; fin = 0;
    for (int l = 0; l < lanes; l++) exp_q.push_back(model(lanes, l, op, num, sh));
    sel = (lanes == 16);
    ptr = 0;
    op_type = op; op_num = num; avg_shift = 5'(sh);
    if (sel) start16 = 1'b1; else start4 = 1'b1;
    drive_fifo(stall);
    @(posedge clk); #1;
    start4 = 1'b0; start16 = 1'b0;
    while (!fin && cyc < 5000) begin
      drive_fifo(stall);
      @(negedge clk);
      pop_f = rd_en;
      if (rd_en) pops++;
      if (wr_en) begin
        pushes++;
        if (exp_q.size() > 0) check("result", $signed(result), exp_q.pop_front());
      end
      if (done) begin
        fin = 1;
        lat = cyc + 1;
      end
      @(posedge clk); #1;
      if (pop_f) ptr++;
      cyc++;
    end
    check("done_seen", fin, 1);
    if (exp_lat >= 0) check("done_latency", lat, exp_lat);
    check("pop_count", pops, lanes * num);
    check("push_count", pushes, lanes);
    check("scoreboard_left", exp_q.size(), 0);
    exp_q.delete();
    in_empty = 1'b1; out_full = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic bad_cmd(input logic [2:0] op, input int num);
    int errs, traffic, busys;
    errs = 0; traffic = 0; busys = 0;
    sel = 1'b0; in_empty = 1'b0; out_full = 1'b0;
    op_type = op; op_num = num; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    check("err_pulse", error, 1);
    traffic += int'(rd_en | wr_en);
    busys   += int'(busy);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      errs    += int'(error);
      traffic += int'(rd_en | wr_en);
      busys   += int'(busy);
    end
    check("err_width", errs, 0);
    check("err_traffic", traffic, 0);
    check("err_busy", busys, 0);
    in_empty = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start16 = 1'b0; sel = 1'b0;
    op_type = '0; op_num = '0; avg_shift = '0;
    in_data = '0; in_weight = '0; in_empty = 1'b1; out_full = 1'b0; ptr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rd_en", rd_en, 0);
    check("rst_out_wr_en", wr_en, 0);
    check("rst_out_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MAC, 4 lanes, 2 rounds: data 1..8 against weight 2 -> 12, 16, 20, 24
    d_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    fill_w(2);
    run_cmd(4, 3'd1, 2, 0, 0, 4*2 + 4 + 1);

    // MAX, 3 rounds: lane0 -5,7,3 -> 7; lane1 all -100 -> -100
    d_q = '{-5, -100, 0, 10, 7, -100, -1, 20, 3, -100, -2, 15};
    fill_w(0);
    run_cmd(4, 3'd4, 3, 0, 0, 4*3 + 4 + 1);

    // AVG, 4 rounds, shift 2: lane0 3,5,7,9 -> 6; lane1 -4 x4 -> -4
    d_q = '{3, -4, 100, -7, 5, -4, 200, -7, 7, -4, -50, -7, 9, -4, 1, -7};
    fill_w(0);
    run_cmd(4, 3'd5, 4, 2, 0, 4*4 + 4 + 1);

    // 16-lane MAC, clean and then with random stalls on the same operands
    d_q.delete(); w_q.delete();
    for (int i = 0; i < 48; i++) begin
      d_q.push_back(DW'(int'($urandom_range(0, 2000)) - 1000));
      w_q.push_back(DW'(int'($urandom_range(0, 200)) - 100));
    end
    run_cmd(16, 3'd1, 3, 0, 0, 16*3 + 16 + 1);
    run_cmd(16, 3'd1, 3, 0, 1, -1);

    bad_cmd(3'd3, 2);
    bad_cmd(3'd1, 0);

    // Reset in the middle of LOAD, then a fresh command
    d_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    fill_w(3);
    sel = 1'b0; op_type = 3'd1; op_num = 2; avg_shift = '0;
    ptr = 0; in_empty = 1'b0; in_data = d_q[0]; in_weight = w_q[0];
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_wr_en", wr_en, 0);
    in_empty = 1'b1;
    d_q = '{-9, 4, -1, 2, -3, 8, -6, 1};
    fill_w(0);
    run_cmd(4, 3'd4, 2, 0, 0, 4*2 + 4 + 1);

    // Overflow of the output width: 200*200 and -200*200
    d_q = '{200, -200, 181, 1};
    w_q = '{200, 200, 181, -1};
    run_cmd(4, 3'd1, 1, 0, 0, 4 + 4 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
